// File: rtl/serial_add_sub.sv
// Bit-serial adder/subtractor: a single full_adder, operands fed LSB-first, start/busy/done handshake.
// Define SERIAL_ADD_SUB_FLAGS_EN to add the zero and overflow flag outputs.

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i ^ c_i;
   assign c_o = (a_i & b_i) | (c_i & (a_i ^ b_i));
endmodule

module serial_add_sub #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             c_out
`ifdef SERIAL_ADD_SUB_FLAGS_EN
  ,output logic             zero,
   output logic             overflow
`endif
);

   localparam int              CW   = $clog2(WIDTH);
   localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] op_a_q, op_a_d;
   logic [WIDTH-1:0] op_b_q, op_b_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic [CW-1:0]    count_q, count_d;
   logic             carry_q, carry_d;
   logic             c_out_q, c_out_d;
`ifdef SERIAL_ADD_SUB_FLAGS_EN
   logic             zero_q, zero_d;
   logic             ovf_q, ovf_d;
`endif

   logic             fa_sum, fa_carry;
   logic             load, step, last_bit;
   logic [WIDTH-1:0] result_shifted;

   full_adder u_full_adder (
      .a_i (op_a_q[0]),
      .b_i (op_b_q[0]),
      .c_i (carry_q),
      .s_o (fa_sum),
      .c_o (fa_carry)
   );

   assign load           = (state_q == ST_IDLE) && start;
   assign step           = (state_q == ST_RUN);
   assign last_bit       = step && (count_q == LAST);
   assign result_shifted = {fa_sum, result_q[WIDTH-1:1]};

   // State register. Reset clears every register so an abort leaves no stale partial result.
   // NOTE: sequential state uses non-blocking assignments so all registers update from the same pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         op_a_q   <= '0;
         op_b_q   <= '0;
         result_q <= '0;
         count_q  <= '0;
         carry_q  <= 1'b0;
         c_out_q  <= 1'b0;
`ifdef SERIAL_ADD_SUB_FLAGS_EN
         zero_q   <= 1'b0;
         ovf_q    <= 1'b0;
`endif
      end else begin
         state_q  <= state_d;
         op_a_q   <= op_a_d;
         op_b_q   <= op_b_d;
         result_q <= result_d;
         count_q  <= count_d;
         carry_q  <= carry_d;
         c_out_q  <= c_out_d;
`ifdef SERIAL_ADD_SUB_FLAGS_EN
         zero_q   <= zero_d;
         ovf_q    <= ovf_d;
`endif
      end
   end

   // Next-state logic; start is only honoured from IDLE, DONE always returns to IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (start)               state_d = ST_RUN;
         ST_RUN:  if (count_q == LAST)     state_d = ST_DONE;
         ST_DONE:                          state_d = ST_IDLE;
         default:                          state_d = ST_IDLE;
      endcase
   end

   // Datapath next-state. Subtraction is a + ~b + 1, the +1 entering as the initial carry.
   // NOTE: every variable gets a hold default first so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      op_a_d   = op_a_q;
      op_b_d   = op_b_q;
      result_d = result_q;
      count_d  = count_q;
      carry_d  = carry_q;
      c_out_d  = c_out_q;
`ifdef SERIAL_ADD_SUB_FLAGS_EN
      zero_d   = zero_q;
      ovf_d    = ovf_q;
`endif
      if (load) begin
         op_a_d  = a;
         op_b_d  = sub ? ~b : b;
         carry_d = sub;
         count_d = '0;
      end else if (step) begin
         op_a_d   = op_a_q >> 1;
         op_b_d   = op_b_q >> 1;
         carry_d  = fa_carry;
         result_d = result_shifted;
         count_d  = count_q + CW'(1);
         if (last_bit) begin
            c_out_d = fa_carry;
`ifdef SERIAL_ADD_SUB_FLAGS_EN
            zero_d  = (result_shifted == '0);
            ovf_d   = carry_q ^ fa_carry;   // carry into MSB xor carry out of MSB
`endif
         end
      end
   end

   // Outputs decoded from registered state only, so busy/done cannot glitch.
   always_comb begin
      busy     = (state_q != ST_IDLE);
      done     = (state_q == ST_DONE);
      result   = result_q;
      c_out    = c_out_q;
`ifdef SERIAL_ADD_SUB_FLAGS_EN
      zero     = zero_q;
      overflow = ovf_q;
`endif
   end

endmodule

// File: tb/tb_serial_add_sub.sv
// Self-checking bench for serial_add_sub: directed 8-bit vectors, corner sequences and
// randomized back-to-back runs on an 8-bit and a 32-bit instance, scoreboarded on done.

module tb_serial_add_sub;

   typedef struct {
      logic [31:0] res;
      logic        c;
      logic        z;
      logic        v;
   } exp_t;

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       s;
      logic [7:0] r;
      logic       c;
      logic       z;
      logic       v;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;

   logic        start8 = 1'b0, sub8 = 1'b0;
   logic [7:0]  a8 = '0, b8 = '0;
   logic        busy8, done8, c_out8;
   logic [7:0]  result8;

   logic        start32 = 1'b0, sub32 = 1'b0;
   logic [31:0] a32 = '0, b32 = '0;
   logic        busy32, done32, c_out32;
   logic [31:0] result32;
`ifdef SERIAL_ADD_SUB_FLAGS_EN
   logic        zero8, ovf8, zero32, ovf32;
`endif

   int   n_checks = 0;
   int   n_errors = 0;
   exp_t q8[$];
   exp_t q32[$];
   vec_t vecs[9];
   logic prev_done8 = 1'b0, prev_done32 = 1'b0;

   always #5 clk = ~clk;

   serial_add_sub #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .result(result8), .c_out(c_out8)
`ifdef SERIAL_ADD_SUB_FLAGS_EN
     ,.zero(zero8), .overflow(ovf8)
`endif
   );

   serial_add_sub #(.WIDTH(32)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start32), .sub(sub32), .a(a32), .b(b32),
      .busy(busy32), .done(done32), .result(result32), .c_out(c_out32)
`ifdef SERIAL_ADD_SUB_FLAGS_EN
     ,.zero(zero32), .overflow(ovf32)
`endif
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: (a + b') + sub modulo 2^w, carry is bit w, overflow by the sign rule.
   function automatic exp_t model(input int w, input logic [31:0] ma, input logic [31:0] mb,
                                  input logic ms);
      logic [32:0] sum;
      logic [31:0] mask, bb, aa;
      exp_t        e;
      mask  = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
      aa    = ma & mask;
      bb    = (ms ? ~mb : mb) & mask;
      sum   = {1'b0, aa} + {1'b0, bb} + 33'(ms);
      e.res = sum[31:0] & mask;
      e.c   = sum[w];
      e.z   = (e.res == 32'h0);
      e.v   = (aa[w-1] == bb[w-1]) && (e.res[w-1] != aa[w-1]);
      return e;
   endfunction

   // Scoreboards: pop on every done pulse and compare the held result.
   always @(negedge clk) begin
      if (rst_n && done8) begin
         check("dut8 done expected", 32'(q8.size() > 0), 32'h1);
         check("dut8 done single-cycle", 32'(prev_done8), 32'h0);
         check("dut8 busy during done", 32'(busy8), 32'h1);
         if (q8.size() > 0) begin
            exp_t e;
            e = q8.pop_front();
            check("dut8 result", 32'(result8), e.res);
            check("dut8 c_out", 32'(c_out8), 32'(e.c));
`ifdef SERIAL_ADD_SUB_FLAGS_EN
            check("dut8 zero", 32'(zero8), 32'(e.z));
            check("dut8 overflow", 32'(ovf8), 32'(e.v));
`endif
         end
      end
      prev_done8 <= done8;
   end

   always @(negedge clk) begin
      if (rst_n && done32) begin
         check("dut32 done expected", 32'(q32.size() > 0), 32'h1);
         check("dut32 done single-cycle", 32'(prev_done32), 32'h0);
         if (q32.size() > 0) begin
            exp_t e;
            e = q32.pop_front();
            check("dut32 result", result32, e.res);
            check("dut32 c_out", 32'(c_out32), 32'(e.c));
`ifdef SERIAL_ADD_SUB_FLAGS_EN
            check("dut32 zero", 32'(zero32), 32'(e.z));
            check("dut32 overflow", 32'(ovf32), 32'(e.v));
`endif
         end
      end
      prev_done32 <= done32;
   end

   // One 8-bit operation; checks done arrives WIDTH+1 negedges after the accepting edge.
   task automatic do_op8(input logic [7:0] ta, input logic [7:0] tb, input logic ts, input exp_t e);
      int lat;
      @(negedge clk);
      a8 = ta; b8 = tb; sub8 = ts; start8 = 1'b1;
      q8.push_back(e);
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      a8 = 8'($urandom); b8 = 8'($urandom); sub8 = ~ts;
      lat = 1;
      while (!done8 && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("dut8 latency", 32'(lat), 32'd9);
      @(negedge clk);
      check("dut8 busy after done", 32'(busy8), 32'h0);
      check("dut8 done after done", 32'(done8), 32'h0);
   endtask

   initial begin
      exp_t e;
      int   waited, extra;

      //         a      b      s     r      c     z     v
      vecs[0] = '{8'h3C, 8'h05, 1'b0, 8'h41, 1'b0, 1'b0, 1'b0};
      vecs[1] = '{8'h05, 8'h06, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0};
      vecs[2] = '{8'h06, 8'h05, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
      vecs[3] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[4] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b0, 1'b1};
      vecs[5] = '{8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b0, 1'b1};
      vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b1, 1'b0};
      vecs[7] = '{8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b0};
      vecs[8] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1};

      repeat (3) @(negedge clk);
      check("reset busy", 32'(busy8), 32'h0);
      check("reset done", 32'(done8), 32'h0);
      check("reset result", 32'(result8), 32'h0);
      check("reset c_out", 32'(c_out8), 32'h0);
      check("reset busy32", 32'(busy32), 32'h0);
`ifdef SERIAL_ADD_SUB_FLAGS_EN
      check("reset zero", 32'(zero8), 32'h0);
      check("reset overflow", 32'(ovf8), 32'h0);
`endif
      rst_n = 1'b1;

      for (int i = 0; i < 9; i++) begin
         e = '{res: 32'(vecs[i].r), c: vecs[i].c, z: vecs[i].z, v: vecs[i].v};
         do_op8(vecs[i].a, vecs[i].b, vecs[i].s, e);
      end

      // start held through RUN and across the DONE edge must be ignored
      @(negedge clk);
      a8 = 8'h12; b8 = 8'h34; sub8 = 1'b0; start8 = 1'b1;
      q8.push_back('{res: 32'h46, c: 1'b0, z: 1'b0, v: 1'b0});
      @(posedge clk);
      @(negedge clk);
      start8 = 1'b0;
      repeat (3) @(negedge clk);
      a8 = 8'hFF; b8 = 8'hFF; sub8 = 1'b1; start8 = 1'b1;
      waited = 0;
      while (!done8 && waited < 40) begin
         @(negedge clk);
         waited++;
      end
      check("ignore-test done seen", 32'(done8), 32'h1);
      @(negedge clk);
      start8 = 1'b0;
      extra = 0;
      repeat (15) begin
         @(negedge clk);
         if (done8) extra++;
      end
      check("ignore-test extra done", 32'(extra), 32'h0);
      check("ignore-test result held", 32'(result8), 32'h46);

      // reset at edge 4 of a RUN aborts
      @(negedge clk);
      a8 = 8'h11; b8 = 8'h22; sub8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      #1 start8 = 1'b0;
      repeat (4) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      check("abort busy", 32'(busy8), 32'h0);
      check("abort done", 32'(done8), 32'h0);
      check("abort result", 32'(result8), 32'h0);
      check("abort c_out", 32'(c_out8), 32'h0);
      q8.delete();
      @(negedge clk);
      rst_n = 1'b1;
      do_op8(8'h10, 8'h20, 1'b0, '{res: 32'h30, c: 1'b0, z: 1'b0, v: 1'b0});

      // start held high continuously: accepted only every WIDTH+2 cycles
      fork
         begin
            @(negedge clk);
            start8 = 1'b1;
            for (int c = 0; c < 200 * 10; c++) begin
               a8 = 8'($urandom); b8 = 8'($urandom); sub8 = 1'($urandom_range(0, 1));
               if (c % 10 == 0) q8.push_back(model(8, 32'(a8), 32'(b8), sub8));
               @(negedge clk);
            end
            start8 = 1'b0;
         end
         begin
            @(negedge clk);
            start32 = 1'b1;
            for (int c = 0; c < 200 * 34; c++) begin
               a32 = $urandom; b32 = $urandom; sub32 = 1'($urandom_range(0, 1));
               if (c % 34 == 0) q32.push_back(model(32, a32, b32, sub32));
               @(negedge clk);
            end
            start32 = 1'b0;
         end
      join

      repeat (40) @(negedge clk);
      check("dut8 scoreboard drained", 32'(q8.size()), 32'h0);
      check("dut32 scoreboard drained", 32'(q32.size()), 32'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_errors);
      $fatal(1, "watchdog");
   end

endmodule
